// File: rtl/updown_pkg.sv
// Shared definitions for the up/down game: verdict encoding used by both the
// comparator and the guesser, plus the guesser's state encoding.
package updown_pkg;

   localparam int DEFAULT_WIDTH = 7;

   localparam logic [1:0] RES_EQUAL   = 2'b00;
   localparam logic [1:0] RES_HIGHER  = 2'b01;
   localparam logic [1:0] RES_LOWER   = 2'b10;
   localparam logic [1:0] RES_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GUESS = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      FAIL  = 3'd4
   } state_t;

endpackage

// File: rtl/updown_guesser.sv
// Automatic up/down player: binary-searches the hidden number by issuing
// guesses and narrowing [lo, hi] from the comparator's verdicts.
module updown_guesser
   import updown_pkg::*;
#(
   parameter int WIDTH        = DEFAULT_WIDTH,
   parameter int MAX_ATTEMPTS = 8,
   parameter int CNT_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] guess_number,
   output logic             guess_valid,
   input  logic [1:0]       result,
   input  logic             result_valid,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] attempts
);

   localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] ATT_LIMIT = CNT_W'(MAX_ATTEMPTS);

   state_t           state, state_next;
   logic [WIDTH-1:0] lo, lo_next;
   logic [WIDTH-1:0] hi, hi_next;
   logic [WIDTH-1:0] guess_q, guess_next;
   logic [CNT_W-1:0] attempts_q, attempts_next;

   logic [WIDTH-1:0] lo_upd, hi_upd;
   logic             found, give_up;

   // Sum needs one extra bit so lo+hi never wraps before halving.
   function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[WIDTH:1];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lo         <= '0;
         hi         <= MAX_VAL;
         guess_q    <= '0;
         attempts_q <= '0;
      end else begin
         state      <= state_next;
         lo         <= lo_next;
         hi         <= hi_next;
         guess_q    <= guess_next;
         attempts_q <= attempts_next;
      end
   end

   // The next guess is registered on entry to GUESS so guess_number is
   // already valid in the cycle guess_valid is high.
   always_comb begin
      state_next    = state;
      lo_next       = lo;
      hi_next       = hi;
      guess_next    = guess_q;
      attempts_next = attempts_q;
      lo_upd        = lo;
      hi_upd        = hi;
      found         = 1'b0;
      give_up       = 1'b0;

      case (state)
         IDLE, DONE, FAIL: begin
            if (start) begin
               lo_next       = '0;
               hi_next       = MAX_VAL;
               guess_next    = midpoint('0, MAX_VAL);
               attempts_next = CNT_W'(1);
               state_next    = GUESS;
            end
         end

         GUESS: begin
            state_next = WAIT;
         end

         WAIT: begin
            if (result_valid) begin
               case (result)
                  RES_EQUAL:  found = 1'b1;
                  RES_HIGHER: begin
                     if (guess_q == '0) give_up = 1'b1;
                     else               hi_upd  = guess_q - 1'b1;
                  end
                  RES_LOWER: begin
                     if (guess_q == MAX_VAL) give_up = 1'b1;
                     else                    lo_upd  = guess_q + 1'b1;
                  end
                  RES_ILLEGAL: give_up = 1'b1;
                  default:     give_up = 1'b1;
               endcase

               if (found) begin
                  state_next = DONE;
               end else begin
                  if ((lo_upd > hi_upd) || (attempts_q == ATT_LIMIT)) begin
                     give_up = 1'b1;
                  end
                  if (give_up) begin
                     state_next = FAIL;
                  end else begin
                     lo_next       = lo_upd;
                     hi_next       = hi_upd;
                     guess_next    = midpoint(lo_upd, hi_upd);
                     attempts_next = attempts_q + 1'b1;
                     state_next    = GUESS;
                  end
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign guess_number = guess_q;
   assign attempts     = attempts_q;
   assign guess_valid  = (state == GUESS);
   assign busy         = (state == GUESS) || (state == WAIT);
   assign done         = (state == DONE);
   assign error        = (state == FAIL);

endmodule

// File: tb/tb_updown_guesser.sv
// Bench for updown_guesser: a table of whole searches against a small
// comparator model, plus hand-written reset and handshake sequences.
module tb_updown_guesser;
   import updown_pkg::*;

   localparam int WIDTH        = 7;
   localparam int MAX_ATTEMPTS = 8;
   localparam int CNT_W        = 4;
   localparam int BUDGET       = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] guess_number;
   logic             guess_valid;
   logic [1:0]       result;
   logic             result_valid;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] attempts;

   int checks = 0;
   int errors = 0;

   // mode 0: honest comparator, 1: always answers higher, 2: answers illegal
   typedef struct {
      int mode;
      int actual;
      bit inject;
      int n_exp;
      int guesses[8];
      bit exp_done;
      bit exp_error;
      int exp_attempts;
      int exp_final;
   } vec_t;

   vec_t vecs[6];

   updown_guesser #(
      .WIDTH(WIDTH),
      .MAX_ATTEMPTS(MAX_ATTEMPTS),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .guess_number(guess_number),
      .guess_valid(guess_valid),
      .result(result),
      .result_valid(result_valid),
      .busy(busy),
      .done(done),
      .error(error),
      .attempts(attempts)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [1:0] respond(input int mode, input int actual, input int g);
      if (mode == 1) return RES_HIGHER;
      if (mode == 2) return RES_ILLEGAL;
      if (g == actual) return RES_EQUAL;
      if (g > actual)  return RES_HIGHER;
      return RES_LOWER;
   endfunction

   task automatic waitGuess(output bit ok);
      int c;
      c = 0;
      while (!guess_valid && c < 20) begin
         tick();
         c++;
      end
      ok = guess_valid;
   endtask

   // One full search; verdict arrives two cycles after each guess_valid.
   task automatic applyStimulus(input vec_t v, input int idx);
      int got[16];
      int n;
      int cycles;
      int last;
      n = 0;
      cycles = 0;
      last = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!(done || error) && cycles < BUDGET) begin
         if (guess_valid) begin
            last = int'(guess_number);
            if (n < 16) got[n] = last;
            n++;
            if (v.inject) begin
               result_valid = 1'b1;
               result = RES_EQUAL;
            end
            tick();
            result_valid = 1'b0;
            if (v.inject) start = 1'b1;
            tick();
            start = 1'b0;
            result_valid = 1'b1;
            result = respond(v.mode, v.actual, last);
            tick();
            result_valid = 1'b0;
            cycles += 3;
         end else begin
            tick();
            cycles++;
         end
      end
      checkOutput($sformatf("v%0d in_time", idx), int'(cycles < BUDGET), 1);
      checkOutput($sformatf("v%0d guess_count", idx), n, v.n_exp);
      for (int i = 0; i < v.n_exp && i < n && i < 8; i++) begin
         checkOutput($sformatf("v%0d guess[%0d]", idx, i), got[i], v.guesses[i]);
      end
      checkOutput($sformatf("v%0d done", idx), int'(done), int'(v.exp_done));
      checkOutput($sformatf("v%0d error", idx), int'(error), int'(v.exp_error));
      checkOutput($sformatf("v%0d attempts", idx), int'(attempts), v.exp_attempts);
      checkOutput($sformatf("v%0d guess_number", idx), int'(guess_number), v.exp_final);
      checkOutput($sformatf("v%0d busy", idx), int'(busy), 0);
   endtask

   initial begin
      bit ok;
      vecs[0] = '{0, 42,  1'b0, 7, '{63, 31, 47, 39, 43, 41, 42, 0},    1'b1, 1'b0, 7, 42};
      vecs[1] = '{0, 127, 1'b0, 8, '{63, 95, 111, 119, 123, 125, 126, 127}, 1'b1, 1'b0, 8, 127};
      vecs[2] = '{0, 0,   1'b0, 7, '{63, 31, 15, 7, 3, 1, 0, 0},        1'b1, 1'b0, 7, 0};
      vecs[3] = '{1, 0,   1'b0, 7, '{63, 31, 15, 7, 3, 1, 0, 0},        1'b0, 1'b1, 7, 0};
      vecs[4] = '{2, 0,   1'b0, 1, '{63, 0, 0, 0, 0, 0, 0, 0},          1'b0, 1'b1, 1, 63};
      vecs[5] = '{0, 42,  1'b1, 7, '{63, 31, 47, 39, 43, 41, 42, 0},    1'b1, 1'b0, 7, 42};

      rst = 1'b1;
      start = 1'b0;
      result_valid = 1'b0;
      result = RES_EQUAL;
      tick();
      tick();
      checkOutput("reset guess_number", int'(guess_number), 0);
      checkOutput("reset guess_valid", int'(guess_valid), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset done", int'(done), 0);
      checkOutput("reset error", int'(error), 0);
      checkOutput("reset attempts", int'(attempts), 0);
      rst = 1'b0;

      result_valid = 1'b1;
      result = RES_EQUAL;
      tick();
      result_valid = 1'b0;
      tick();
      checkOutput("idle verdict done", int'(done), 0);
      checkOutput("idle verdict busy", int'(busy), 0);
      checkOutput("idle verdict guess_valid", int'(guess_valid), 0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Abort mid-search: reset during WAIT of the third guess.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         waitGuess(ok);
         checkOutput($sformatf("abort guess%0d seen", k), int'(ok), 1);
         tick();
         tick();
         result_valid = 1'b1;
         result = respond(0, 42, int'(guess_number));
         tick();
         result_valid = 1'b0;
      end
      waitGuess(ok);
      checkOutput("abort third guess", int'(guess_number), 47);
      tick();
      checkOutput("abort wait busy", int'(busy), 1);
      rst = 1'b1;
      tick();
      checkOutput("abort busy", int'(busy), 0);
      checkOutput("abort guess_valid", int'(guess_valid), 0);
      checkOutput("abort guess_number", int'(guess_number), 0);
      checkOutput("abort attempts", int'(attempts), 0);
      checkOutput("abort done", int'(done), 0);
      checkOutput("abort error", int'(error), 0);

      start = 1'b1;
      tick();
      checkOutput("rst over start busy", int'(busy), 0);
      rst = 1'b0;
      tick();
      start = 1'b0;
      checkOutput("restart guess_valid", int'(guess_valid), 1);
      checkOutput("restart guess_number", int'(guess_number), 63);
      tick();
      checkOutput("restart attempts", int'(attempts), 1);
      checkOutput("restart guess_valid pulse", int'(guess_valid), 0);
      checkOutput("restart busy", int'(busy), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_guesser.md
Name: updown_guesser

Overview:
- Automatic player for the up/down game: generates guesses, consumes the 2-bit comparison verdict for each guess, and binary-searches to the hidden number.
- Sits on the opposite side of the compare interface. It drives guess_number into the comparator and receives result back through a valid-qualified handshake.
- Used for self-play demo mode and for exhaustive hardware self-test of the comparator path.

Parameters:
- WIDTH, 7, bit width of guess_number; search range is 0 .. 2^WIDTH-1.
- MAX_ATTEMPTS, 8, guesses allowed before declaring failure; must be >= WIDTH+1.
- CNT_W, 4, width of the attempts counter; must hold MAX_ATTEMPTS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new search; sampled in IDLE, DONE and FAIL, ignored otherwise.
- guess_number  out  WIDTH  current guess, held stable from guess_valid until the next guess.
- guess_valid  out  1  one-cycle pulse: a new guess is presented.
- result  in  2  verdict for the current guess: 00 equal, 01 guess higher than actual, 10 guess lower than actual, 11 illegal.
- result_valid  in  1  result is valid this cycle; accepted only in WAIT.
- busy  out  1  high in GUESS and WAIT.
- done  out  1  high while in DONE; guess_number then equals the found value.
- error  out  1  high while in FAIL.
- attempts  out  CNT_W  number of guesses issued in the current or last search.

Behaviour:
- Reset values: guess_number=0, guess_valid=0, busy=0, done=0, error=0, attempts=0, lo=0, hi=2^WIDTH-1, state=IDLE. rst mid-search aborts immediately to these values.
- States:
  - IDLE: on start, set lo=0, hi=max, attempts=0, go to GUESS.
  - GUESS (1 cycle): guess_number <= (lo+hi)>>1, computed in WIDTH+1 bits; guess_valid=1; attempts+1; go to WAIT.
  - WAIT: hold until result_valid, then:
    - 00 -> DONE.
    - 01 -> if mid==0 -> FAIL, else hi=mid-1.
    - 10 -> if mid==max -> FAIL, else lo=mid+1.
    - 11 -> FAIL.
    - After updating lo/hi: if lo>hi, or attempts==MAX_ATTEMPTS and result!=00 -> FAIL; else -> GUESS.
  - DONE / FAIL: outputs held; start restarts exactly as from IDLE.
- Timing:
  - Latency: start at cycle n -> guess_valid at n+1.
  - result_valid at cycle m -> next guess_valid at m+1, or done/error asserted at m+1.
  - Minimum 2 cycles per guess.
- Handshake and edge cases:
  - result_valid outside WAIT is ignored.
  - result_valid in the same cycle as guess_valid is not accepted; it is a stale verdict.
  - start while busy is ignored.
  - rst has priority over start.
  - guess_number retains its last value in DONE and FAIL.

Decomposition:
- Shared package updown_pkg holds:
  - RES_EQUAL=2'b00, RES_HIGHER=2'b01, RES_LOWER=2'b10, RES_ILLEGAL=2'b11, shared with compare.
  - State encoding IDLE/GUESS/WAIT/DONE/FAIL.
  - Default WIDTH=7.
- No sub-module needed: the midpoint and bound update is a few lines of arithmetic inside the FSM.

Test Plan:
- Bench wires a compare model with actual=42 and returns result 2 cycles after each guess_valid -> guesses 63,31,47,39,43,41,42; done=1, guess_number=42, attempts=7, error=0.
- actual=127 -> guesses 63,95,111,119,123,125,126,127; done=1, attempts=8. actual=0 -> 63,31,15,7,3,1,0; done=1, attempts=7.
- Bench answers 01 (higher) to every guess -> at guess 0 the bench answers 01 again -> error=1, done=0, attempts=7. Also: result=11 on the first guess -> error=1, attempts=1.
- result_valid pulsed in IDLE and in the guess_valid cycle -> no state change; the search for actual=42 still completes in 7 guesses. start pulsed during WAIT -> ignored.
- rst asserted during WAIT after 3 guesses -> next cycle all outputs are at reset values. A new start then yields first guess 63 with attempts=1.
